// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request bus plus the decode-side valid/ready buffer
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_pc_plus;
    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc_plus,
        input  imem_ack, imem_rdata, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc_plus,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and req/ack fetch FSM feeding a one-entry decode buffer, with redirect squash
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                STEP       = 4,
    parameter int                ALIGN_BITS = 2,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      bus,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  fetch_cnt
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
    state_t            state;
    logic [ADDR_W-1:0] drain_addr;
    logic [ADDR_W-1:0] target;
    assign target           = redirect_addr & MASK;
    assign bus.imem_req     = state != HOLD;
    assign bus.imem_addr    = state == DRAIN ? drain_addr : pc;
    assign bus.inst_pc_plus = bus.inst_pc + ADDR_W'(STEP);
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            drain_addr     <= '0;
            bus.inst_valid <= 1'b0;
            bus.inst_out   <= '0;
            bus.inst_pc    <= '0;
            fetch_cnt      <= '0;
        end else begin
            if (state == HOLD && bus.inst_ready) fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (redirect) begin
                pc             <= target;
                bus.inst_valid <= 1'b0;
                // an unacked request must still be drained before a new one may issue
                if (state == FETCH && !bus.imem_ack) begin
                    drain_addr <= pc;
                    state      <= DRAIN;
                end else if (state != DRAIN || bus.imem_ack) begin
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: if (bus.imem_ack) begin
                        bus.inst_out   <= bus.imem_rdata;
                        bus.inst_pc    <= pc;
                        bus.inst_valid <= 1'b1;
                        pc             <= pc + ADDR_W'(STEP);
                        state          <= HOLD;
                    end
                    HOLD: if (bus.inst_ready) begin
                        bus.inst_valid <= 1'b0;
                        state          <= FETCH;
                    end
                    default: if (bus.imem_ack) state <= FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected decode deliveries
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic [31:0] pc;
    logic [15:0] fetch_cnt;
    int          lat = 1;
    int          wcnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    typedef struct packed {
        logic [31:0] ipc;
        logic [31:0] data;
        logic [31:0] plus;
    } exp_t;
    exp_t exp_q[$];
    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) b ();
    fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .bus(b.master), .redirect(redirect),
        .redirect_addr(redirect_addr), .pc(pc), .fetch_cnt(fetch_cnt)
    );
    always #5 clk = ~clk;
    // memory: ack arrives once the request has been held lat cycles (lat=1 acks in the first one)
    always @(posedge clk) wcnt <= (rst || !b.imem_req || b.imem_ack) ? 0 : wcnt + 1;
    assign b.imem_ack   = b.imem_req && (wcnt == lat - 1);
    assign b.imem_rdata = {16'hDEAD, b.imem_addr[15:0]};
    assign b.inst_ready = ready;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        exp_q.push_back('{ipc: a, data: d, plus: p});
    endtask
    always @(negedge clk) begin
        if (!rst && b.inst_valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected delivery: got pc %0h data %0h expected none", b.inst_pc, b.inst_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver_pc", b.inst_pc, e.ipc);
                chk("deliver_data", b.inst_out, e.data);
                chk("deliver_pc_plus", b.inst_pc_plus, e.plus);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        push(32'h100, 32'hDEAD0100, 32'h104);
        push(32'h104, 32'hDEAD0104, 32'h108);
        push(32'h108, 32'hDEAD0108, 32'h10C);
        push(32'h10C, 32'hDEAD010C, 32'h110);
        push(32'h2000, 32'hDEAD2000, 32'h2004);
        push(32'h40, 32'hDEAD0040, 32'h44);
        push(32'hFFFFFFFC, 32'hDEADFFFC, 32'h0);
        tick;
        tick;
        chk("rst_pc", pc, 32'h100);
        chk("rst_valid", b.inst_valid, 0);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_inst_out", b.inst_out, 0);
        chk("rst_inst_pc", b.inst_pc, 0);
        rst = 1'b0;
        chk("req_after_rst", b.imem_req, 1);
        tick;
        chk("first_valid", b.inst_valid, 1);
        chk("hold_req", b.imem_req, 0);
        tick;
        chk("cnt_after_2", fetch_cnt, 1);
        tick;
        tick;
        chk("cnt_after_4", fetch_cnt, 2);
        tick;
        tick;
        chk("cnt_after_6", fetch_cnt, 3);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_pc", b.inst_pc, 32'h10C);
            chk("bp_data", b.inst_out, 32'hDEAD010C);
            chk("bp_req", b.imem_req, 0);
            chk("bp_cnt", fetch_cnt, 3);
        end
        ready = 1'b1;
        lat = 4;
        tick;
        chk("bp_release_cnt", fetch_cnt, 4);
        chk("w1_addr", b.imem_addr, 32'h110);
        tick;
        redirect = 1'b1;
        redirect_addr = 32'h2003;
        tick;
        redirect = 1'b0;
        chk("drain_addr", b.imem_addr, 32'h110);
        chk("drain_req", b.imem_req, 1);
        chk("drain_pc", pc, 32'h2000);
        chk("drain_valid", b.inst_valid, 0);
        tick;
        chk("drain_addr_ack", b.imem_addr, 32'h110);
        chk("drain_ack", b.imem_ack, 1);
        tick;
        chk("post_drain_addr", b.imem_addr, 32'h2000);
        chk("post_drain_valid", b.inst_valid, 0);
        for (int i = 0; i < 20 && fetch_cnt != 16'd5; i++) tick;
        chk("cnt_after_drain", fetch_cnt, 5);
        lat = 1;
        redirect = 1'b1;
        redirect_addr = 32'h40;
        tick;
        redirect = 1'b0;
        chk("redir_ack_valid", b.inst_valid, 0);
        chk("redir_ack_addr", b.imem_addr, 32'h40);
        chk("redir_ack_req", b.imem_req, 1);
        tick;
        tick;
        chk("cnt_after_40", fetch_cnt, 6);
        redirect = 1'b1;
        redirect_addr = 32'hFFFFFFFE;
        tick;
        redirect = 1'b0;
        chk("wrap_pc_pre", pc, 32'hFFFFFFFC);
        tick;
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_inst_pc", b.inst_pc, 32'hFFFFFFFC);
        chk("wrap_pc_plus", b.inst_pc_plus, 32'h0);
        tick;
        chk("cnt_after_wrap", fetch_cnt, 7);
        lat = 4;
        redirect = 1'b1;
        redirect_addr = 32'h300;
        tick;
        redirect = 1'b0;
        chk("drain2_addr", b.imem_addr, 32'h0);
        chk("drain2_pc", pc, 32'h300);
        rst = 1'b1;
        tick;
        chk("mid_rst_pc", pc, 32'h100);
        chk("mid_rst_valid", b.inst_valid, 0);
        chk("mid_rst_cnt", fetch_cnt, 0);
        chk("mid_rst_req", b.imem_req, 1);
        chk("mid_rst_addr", b.imem_addr, 32'h100);
        rst = 1'b0;
        tick;
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
